latch_wr_ctrl: RTL and testbench



---
 rtl/latch_pkg.sv | 15 +
 rtl/latch_wr_ctrl_onehot_dec.sv | 19 +
 rtl/latch_wr_ctrl.sv | 92 +++++++++
 tb/tb_latch_wr_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/latch_pkg.sv
// rtl/latch_pkg.sv - shared state encoding and default sizing for the latch write controller
package latch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_DEPTH     = 4;
  localparam int DEFAULT_PULSE_CYC = 2;

endpackage

// File: rtl/latch_wr_ctrl_onehot_dec.sv
// rtl/latch_wr_ctrl_onehot_dec.sv - address to one-hot decoder with enable
// Addresses at or beyond DEPTH decode to all-zero.
module onehot_dec #(
  parameter int AW    = 2,
  parameter int DEPTH = 4
) (
  input  logic             en,
  input  logic [AW-1:0]    addr,
  output logic [DEPTH-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (en && (addr == AW'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/latch_wr_ctrl.sv
// rtl/latch_wr_ctrl.sv - SETUP/PULSE/HOLD write sequencer for a gated D latch bank
// Optional read-back compare with sticky wr_err when LATCH_WR_VERIFY_EN is defined.
module latch_wr_ctrl
  import latch_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AW        = $clog2(DEPTH),
  parameter int PULSE_CYC = DEFAULT_PULSE_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] lat_d,
  output logic [DEPTH-1:0] lat_en,
  output logic             busy
`ifdef LATCH_WR_VERIFY_EN
  ,
  input  logic [WIDTH-1:0] rd_q,
  output logic             wr_err
`endif
);

  state_t           state;
  logic [3:0]       cnt;
  logic [AW-1:0]    addr_q;
  logic [DEPTH-1:0] dec_en;

  onehot_dec #(.AW(AW), .DEPTH(DEPTH)) u_dec (
    .en     (state == SETUP),
    .addr   (addr_q),
    .onehot (dec_en)
  );

  // lat_en comes straight from this flop so the latch gates never see decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      lat_d    <= '0;
      lat_en   <= '0;
      wr_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_valid && wr_ready) begin
            addr_q   <= wr_addr;
            lat_d    <= wr_data;
            wr_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          lat_en <= dec_en;
          cnt    <= 4'(PULSE_CYC - 1);
          state  <= PULSE;
        end
        PULSE: begin
          if (cnt == 4'd0) begin
            lat_en <= '0;
            state  <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          wr_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LATCH_WR_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
    end else if (state == HOLD) begin
      if ((rd_q != lat_d) || (int'(addr_q) >= DEPTH)) wr_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_latch_wr_ctrl.sv
// tb/tb_latch_wr_ctrl.sv - self-checking bench for latch_wr_ctrl (default and DEPTH=3 instances)
module tb_latch_wr_ctrl;

  localparam int P0 = 2, D0 = 4;
  localparam int P1 = 3, D1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] valid;
  logic [1:0] addr [2];
  logic [7:0] data [2];

  logic       ready0, busy0, ready1, busy1;
  logic [7:0] d0, d1;
  logic [3:0] en0;
  logic [2:0] en1;

  latch_wr_ctrl #(.WIDTH(8), .DEPTH(D0), .PULSE_CYC(P0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(valid[0]), .wr_ready(ready0),
    .wr_addr(addr[0]), .wr_data(data[0]), .lat_d(d0), .lat_en(en0), .busy(busy0)
`ifdef LATCH_WR_VERIFY_EN
    , .rd_q(d0), .wr_err()
`endif
  );

  latch_wr_ctrl #(.WIDTH(8), .DEPTH(D1), .PULSE_CYC(P1)) dut3 (
    .clk(clk), .rst_n(rst_n), .wr_valid(valid[1]), .wr_ready(ready1),
    .wr_addr(addr[1]), .wr_data(data[1]), .lat_d(d1), .lat_en(en1), .busy(busy1)
`ifdef LATCH_WR_VERIFY_EN
    , .rd_q(d1), .wr_err()
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: cycles elapsed since acceptance (0 = idle and ready).
  int         ph [2];
  logic [7:0] md [2];
  int         ma [2];
  int         pc [2];
  int         dp [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      ph[u] = 0; md[u] = 8'h00; ma[u] = 0;
    end
  endtask

  task automatic model_edge();
    for (int u = 0; u < 2; u++) begin
      if (ph[u] == 0) begin
        if (valid[u]) begin
          ph[u] = 1; md[u] = data[u]; ma[u] = int'(addr[u]);
        end
      end else begin
        ph[u]++;
        if (ph[u] == pc[u] + 3) ph[u] = 0;
      end
    end
  endtask

  function automatic logic [31:0] exp_en(int u);
    if (ph[u] >= 2 && ph[u] <= pc[u] + 1 && ma[u] < dp[u]) return 32'(1) << ma[u];
    return 32'd0;
  endfunction

  task automatic check_all(input string where);
    chk({where, " ready0"}, 32'(ready0), 32'(ph[0] == 0));
    chk({where, " busy0"},  32'(busy0),  32'(ph[0] != 0));
    chk({where, " en0"},    32'(en0),    exp_en(0));
    chk({where, " d0"},     32'(d0),     32'(md[0]));
    chk({where, " ready1"}, 32'(ready1), 32'(ph[1] == 0));
    chk({where, " busy1"},  32'(busy1),  32'(ph[1] != 0));
    chk({where, " en1"},    32'(en1),    exp_en(1));
    chk({where, " d1"},     32'(d1),     32'(md[1]));
    chk({where, " onehot0"}, 32'($countones(en0) <= 1), 32'd1);
  endtask

  task automatic step(input string where);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all(where);
  endtask

  int acc [$];
  int cyc;

  initial begin
    pc[0] = P0; pc[1] = P1; dp[0] = D0; dp[1] = D1;
    valid = 2'b11;
    addr[0] = 2'd1; addr[1] = 2'd1;
    data[0] = 8'h77; data[1] = 8'h77;
    model_reset();

    // Reset held with valid asserted: no handshake may occur.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_all("reset");
    end
    rst_n = 1'b1;
    valid = 2'b00;
    step("idle");

    // Single write addr 2 / A5 on the default instance.
    valid[0] = 1'b1; addr[0] = 2'd2; data[0] = 8'hA5;
    step("single_acc");
    valid[0] = 1'b0;
    chk("single_setup_en", 32'(en0), 32'd0);
    chk("single_setup_d", 32'(d0), 32'hA5);
    step("single_p1");
    chk("single_pulse_en", 32'(en0), 32'b0100);
    repeat (4) step("single");

    // Back-to-back with valid held: addr 0/3C then addr 1/C3.
    valid[0] = 1'b1; addr[0] = 2'd0; data[0] = 8'h3C;
    cyc = 0;
    acc.delete();
    repeat (12) begin
      if (valid[0] && ready0) acc.push_back(cyc);
      step("b2b");
      cyc++;
      if (cyc == 1) begin addr[0] = 2'd1; data[0] = 8'hC3; end
      if (acc.size() == 2) valid[0] = 1'b0;
    end
    valid[0] = 1'b0;
    chk("b2b_count", 32'(acc.size()), 32'd2);
    if (acc.size() == 2) chk("b2b_gap", 32'(acc[1] - acc[0]), 32'(P0 + 3));
    repeat (6) step("b2b_drain");

    // Out-of-range address on the DEPTH=3 instance.
    valid[1] = 1'b1; addr[1] = 2'd3; data[1] = 8'h5E;
    step("oor_acc");
    valid[1] = 1'b0;
    chk("oor_busy", 32'(busy1), 32'd1);
    repeat (P1 + 3) step("oor");

    // Asynchronous reset mid-PULSE.
    valid[0] = 1'b1; addr[0] = 2'd3; data[0] = 8'h5A;
    step("mid_acc");
    valid[0] = 1'b0;
    step("mid_pulse");
    chk("mid_pulse_en", 32'(en0), 32'b1000);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_en0", 32'(en0), 32'd0);
    chk("async_busy0", 32'(busy0), 32'd0);
    chk("async_ready0", 32'(ready0), 32'd1);
    chk("async_d0", 32'(d0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset");

    // Randomized traffic on both instances.
    repeat (400) begin
      for (int u = 0; u < 2; u++) begin
        valid[u] = ($urandom_range(0, 2) != 0);
        addr[u]  = 2'($urandom_range(0, 3));
        data[u]  = 8'($urandom);
      end
      step("rand");
    end
    valid = 2'b00;
    repeat (8) step("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
